// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int   MAX_WIDTH   = 9;

    // Callers zero-extend narrower words; zeros do not disturb the XOR.
    function automatic logic parity_calc(
        input logic [MAX_WIDTH-1:0] data,
        input logic                 odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with occupancy count and registered overflow pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = mem_q[rptr_q];

    // Fullness is judged before any same-cycle pop.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = push && full;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from an internal FIFO; single-frame and burst modes.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   send,
    input  logic                   burst,
    output logic                   tx_serial,
    output logic                   busy,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(WIDTH);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] BIT_MAX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] STOP_MAX = IW'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 burst_q, burst_d;
    logic                 tx_q, tx_d;
    logic                 pop, tick;
    logic [WIDTH-1:0]     head;
    logic [MAX_WIDTH-1:0] head_ext;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (wr_en),
        .wr_data  (wr_data),
        .pop      (pop),
        .rd_data  (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign tx_serial = tx_q;
    assign busy      = (state_q != IDLE);
    assign tick      = (baud_q == BAUD_MAX);

    always_comb begin
        head_ext              = '0;
        head_ext[WIDTH-1:0]   = head;
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        burst_d = burst_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!empty && (send || burst)) begin
                    pop     = 1'b1;
                    shift_d = head;
                    par_d   = parity_calc(head_ext, PARITY_ODD != 0);
                    burst_d = burst;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_MAX) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + IW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    baud_d = '0;
                    if (bit_q == STOP_MAX) begin
                        bit_d = '0;
                        // Back-to-back frames in burst mode: no idle gap.
                        if (burst_q && !empty) begin
                            pop     = 1'b1;
                            shift_d = head;
                            par_d   = parity_calc(head_ext, PARITY_ODD != 0);
                            state_d = START;
                        end else begin
                            burst_d = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is registered from the next state so it lines up with busy.
    always_comb begin
        unique case (state_d)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            burst_q <= 1'b0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            burst_q <= burst_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two configurations against a frame-level model.
module tb_uart_tx_fifo;

    localparam int CPB = 4;
    localparam int D   = 4;
    localparam int PEN [2] = '{0, 1};
    localparam int POD [2] = '{0, 1};
    localparam int STB [2] = '{1, 2};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic       send = 1'b0;
    logic       burst = 1'b0;
    logic [7:0] wr_data = '0;

    logic       tx_a, busy_a, full_a, empty_a, ovf_a;
    logic       tx_b, busy_b, full_b, empty_b, ovf_b;
    logic [2:0] cnt_a, cnt_b;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .WIDTH(8), .DEPTH(D), .CLKS_PER_BIT(CPB),
        .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .send(send), .burst(burst), .tx_serial(tx_a), .busy(busy_a),
        .full(full_a), .empty(empty_a), .count(cnt_a), .overflow(ovf_a)
    );

    uart_tx_fifo #(
        .WIDTH(8), .DEPTH(D), .CLKS_PER_BIT(CPB),
        .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
    ) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .send(send), .burst(burst), .tx_serial(tx_b), .busy(busy_b),
        .full(full_b), .empty(empty_b), .count(cnt_b), .overflow(ovf_b)
    );

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: a word queue per DUT plus the bit list of the frame on the line.
    int  fq [2][$];
    bit  inf [2];
    bit  bf [2];
    bit  eovf [2];
    int  pos [2];
    int  flen [2];
    bit  fb [2][16];

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                for (int i = 0; i < 2; i++) begin
                    fq[i].delete();
                    inf[i] = 0; bf[i] = 0; eovf[i] = 0; pos[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    int sz;
                    bit st;
                    logic [7:0] w;
                    int n;
                    sz = fq[i].size();
                    st = 0;
                    if (!inf[i]) begin
                        if (sz > 0 && (send || burst)) begin
                            st = 1;
                            bf[i] = burst;
                        end
                    end else if (pos[i] == flen[i] * CPB - 1) begin
                        if (bf[i] && sz > 0) st = 1;
                        else begin
                            inf[i] = 0;
                            bf[i] = 0;
                        end
                    end else begin
                        pos[i]++;
                    end
                    if (st) begin
                        w = 8'(fq[i].pop_front());
                        n = 0;
                        fb[i][n++] = 1'b0;
                        for (int k = 0; k < 8; k++) fb[i][n++] = w[k];
                        if (PEN[i] != 0) fb[i][n++] = (^w) ^ (POD[i] != 0);
                        for (int s = 0; s < STB[i]; s++) fb[i][n++] = 1'b1;
                        flen[i] = n;
                        pos[i] = 0;
                        inf[i] = 1;
                    end
                    eovf[i] = wr_en && (sz == D);
                    if (wr_en && sz < D) fq[i].push_back(int'(wr_data));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                for (int i = 0; i < 2; i++) begin
                    logic etx;
                    int sz;
                    sz  = fq[i].size();
                    etx = inf[i] ? fb[i][pos[i] / CPB] : 1'b1;
                    chk(i ? "tx_b" : "tx_a", i ? tx_b : tx_a, etx);
                    chk(i ? "busy_b" : "busy_a", i ? busy_b : busy_a, inf[i]);
                    chk(i ? "count_b" : "count_a",
                        i ? cnt_b : cnt_a, sz);
                    chk(i ? "empty_b" : "empty_a",
                        i ? empty_b : empty_a, sz == 0);
                    chk(i ? "full_b" : "full_a",
                        i ? full_b : full_a, sz == D);
                    chk(i ? "ovf_b" : "ovf_a", i ? ovf_b : ovf_a, eovf[i]);
                end
            end
        end
    end

    initial begin
        int nb_a, nb_b, ov;
        logic [9:0] bits;
        logic [7:0] by;

        #2 reset = 1'b0;
        #1 armed = 1'b1;
        chk("rst_tx", tx_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_empty", empty_a, 1);
        chk("rst_count", cnt_b, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc();

        // 0xA5 single frame
        wr_data = 8'hA5; wr_en = 1; cyc(); wr_en = 0;
        chk("a5_count_pre", cnt_a, 1);
        send = 1; cyc(); send = 0;
        chk("a5_count_post", cnt_a, 0);
        nb_a = 0; nb_b = 0; bits = '0;
        for (int c = 0; c < 60; c++) begin
            nb_a += int'(busy_a);
            nb_b += int'(busy_b);
            if (c % 4 == 2 && c < 40) bits[c / 4] = tx_a;
            if (c == 38) chk("a5_parity_odd", tx_b, 1);
            cyc();
        end
        chk("a5_bits", bits, 10'b1101001010);
        chk("a5_busy_len", nb_a, 40);
        chk("b_busy_len", nb_b, 48);

        // 0x07: odd parity bit 0 on dut_b
        wr_data = 8'h07; wr_en = 1; cyc(); wr_en = 0;
        send = 1; cyc(); send = 0;
        by = '0;
        for (int c = 0; c < 60; c++) begin
            if (c % 4 == 2 && c >= 4 && c < 36) by[(c - 4) / 4] = tx_a;
            if (c == 38) chk("07_parity_odd", tx_b, 0);
            cyc();
        end
        chk("07_byte", by, 8'h07);

        // Burst of four words
        for (int k = 0; k < 4; k++) begin
            wr_data = 8'(8'h11 * (k + 1)); wr_en = 1; cyc();
        end
        wr_en = 0;
        burst = 1;
        nb_a = 0; nb_b = 0;
        for (int c = 0; c < 250; c++) begin
            if (c == 3) burst = 0;
            cyc();
            nb_a += int'(busy_a);
            nb_b += int'(busy_b);
        end
        chk("burst_len_a", nb_a, 160);
        chk("burst_len_b", nb_b, 192);
        chk("burst_empty", empty_a, 1);
        chk("burst_idle", busy_b, 0);

        // Overflow
        ov = 0;
        for (int k = 0; k < 5; k++) begin
            wr_data = 8'(8'h51 + k); wr_en = 1; cyc();
            ov += int'(ovf_a);
            if (k == 3) chk("full_4th", full_a, 1);
        end
        wr_en = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            ov += int'(ovf_a);
        end
        chk("ovf_pulses", ov, 1);
        chk("ovf_count", cnt_a, 4);
        send = 1; cyc(); send = 0;
        by = '0;
        for (int c = 0; c < 60; c++) begin
            if (c % 4 == 2 && c >= 4 && c < 36) by[(c - 4) / 4] = tx_a;
            cyc();
        end
        chk("ovf_first_word", by, 8'h51);

        // Reset on the third data bit
        send = 1; cyc(); send = 0;
        repeat (13) cyc();
        reset = 1'b0;
        #1;
        chk("mid_rst_tx", tx_a, 1);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_count", cnt_a, 0);
        chk("mid_rst_busy_b", busy_b, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        cyc();
        send = 1; cyc(); cyc(); send = 0;
        nb_a = 0;
        for (int c = 0; c < 10; c++) begin
            nb_a += int'(busy_a);
            cyc();
        end
        chk("empty_send_ignored", nb_a, 0);

        // Write and send in the same cycle on an empty FIFO
        wr_data = 8'h3C; wr_en = 1; send = 1; cyc();
        wr_en = 0; send = 0;
        chk("same_cycle_busy", busy_a, 0);
        chk("same_cycle_count", cnt_a, 1);
        send = 1; cyc(); send = 0;
        chk("next_send_busy", busy_a, 1);
        repeat (60) cyc();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            wr_en   = ($urandom_range(0, 99) < 30);
            wr_data = 8'($urandom);
            send    = ($urandom_range(0, 99) < 8);
            burst   = ($urandom_range(0, 99) < 4);
            cyc();
        end
        wr_en = 0; send = 0; burst = 0;
        repeat (300) cyc();

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
